// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
package load_store_unit_pkg;

  // RISC-V funct3 encodings of the load/store access widths
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Encoding is {is_store, funct3}: [1:0] = size, [2] = unsigned, [3] = store
  typedef enum logic [3:0] {
    LB  = {1'b0, FUNCT3_LB},
    LH  = {1'b0, FUNCT3_LH},
    LW  = {1'b0, FUNCT3_LW},
    LBU = {1'b0, FUNCT3_LBU},
    LHU = {1'b0, FUNCT3_LHU},
    SB  = {1'b1, FUNCT3_SB},
    SH  = {1'b1, FUNCT3_SH},
    SW  = {1'b1, FUNCT3_SW}
  } load_store_func_code;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} lsu_state_e;

  function automatic logic [1:0] lsu_size(load_store_func_code op);
    return op[1:0];
  endfunction

  function automatic logic lsu_is_store(load_store_func_code op);
    return op[3];
  endfunction

  function automatic logic lsu_is_unsigned(load_store_func_code op);
    return op[2];
  endfunction

  // Halfwords need bit 0 clear, words need both low bits clear
  function automatic logic lsu_misaligned(load_store_func_code op, logic [1:0] off);
    logic mis;
    case (lsu_size(op))
      2'b01:   mis = off[0];
      2'b10:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering for stores and extract/extend for loads.
module load_store_unit_lane_align (
  input  logic [1:0]  req_size_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] rdata_shifted;

  assign rdata_shifted = rdata_i >> {ld_off_i, 3'b000};

  // Replicate store data across lanes and pick byte enables by size/offset
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (req_size_i)
      2'b00: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = req_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Pull the addressed byte/half down to bit 0 and sign- or zero-extend
  always_comb begin
    ld_data_o = rdata_i;
    case (ld_size_i)
      2'b00: ld_data_o = {{24{~ld_unsigned_i & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01: ld_data_o = {{16{~ld_unsigned_i & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one data-bus transaction per accepted Decode request.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en_lsu_ip,
  input  load_store_func_code lsu_operator_ip,
  input  logic [31:0]         addr_ip,
  input  logic                addr_valid_ip,
  input  logic [31:0]         wdata_ip,
  output logic [31:0]         mem_data_op,
  output logic                mem_data_valid_op,
  output logic                lsu_busy_op,
  output logic                lsu_misaligned_op,
  output logic                lsu_timeout_op,
  output logic                data_req_op,
  input  logic                data_gnt_ip,
  output logic [31:0]         data_addr_op,
  output logic                data_we_op,
  output logic [3:0]          data_be_op,
  output logic [31:0]         data_wdata_op,
  input  logic                data_rvalid_ip,
  input  logic [31:0]         data_rdata_ip
);

  lsu_state_e           state_q, state_d;
  load_store_func_code  op_q, op_d;
  logic [1:0]           off_q, off_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 req_q, req_d, we_q, we_d;
  logic [31:0]          addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          mem_data_q, mem_data_d;
  logic                 valid_q, valid_d, timeout_q, timeout_d;

  logic        req_present, misaligned, accept;
  logic [3:0]  steer_be;
  logic [31:0] steer_wdata, ld_data;

  assign req_present = (state_q == IDLE) && en_lsu_ip && addr_valid_ip;
  assign misaligned  = lsu_misaligned(lsu_operator_ip, addr_ip[1:0]);
  assign accept      = req_present && !misaligned;
  assign cnt_inc     = cnt_q + CNT_WIDTH'(1);

  load_store_unit_lane_align u_lane_align (
    .req_size_i   (lsu_size(lsu_operator_ip)),
    .req_off_i    (addr_ip[1:0]),
    .wdata_i      (wdata_ip),
    .be_o         (steer_be),
    .wdata_o      (steer_wdata),
    .ld_size_i    (lsu_size(op_q)),
    .ld_unsigned_i(lsu_is_unsigned(op_q)),
    .ld_off_i     (off_q),
    .rdata_i      (data_rdata_ip),
    .ld_data_o    (ld_data)
  );

  // Next-state: accept in IDLE, hold bus until grant, wait for response or timeout
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    mem_data_d = mem_data_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          op_d    = lsu_operator_ip;
          off_d   = addr_ip[1:0];
          req_d   = 1'b1;
          we_d    = lsu_is_store(lsu_operator_ip);
          addr_d  = {addr_ip[31:2], 2'b00};
          wdata_d = steer_wdata;
          be_d    = steer_be;
        end
      end
      REQ: begin
        if (data_gnt_ip) begin
          state_d = WAIT_RESP;
          req_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      WAIT_RESP: begin
        // A response in the timeout cycle still completes normally
        if (data_rvalid_ip) begin
          state_d = DONE;
          if (!lsu_is_store(op_q)) begin
            mem_data_d = ld_data;
            valid_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          if ((RESP_TIMEOUT != 0) && (cnt_inc == CNT_WIDTH'(RESP_TIMEOUT))) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= LB;
      off_q      <= 2'b00;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      mem_data_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      mem_data_q <= mem_data_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_data_op       = mem_data_q;
  assign mem_data_valid_op = valid_q;
  assign lsu_timeout_op    = timeout_q;
  assign data_req_op       = req_q;
  assign data_addr_op      = addr_q;
  assign data_we_op        = we_q;
  assign data_be_op        = be_q;
  assign data_wdata_op     = wdata_q;

  // DONE keeps busy low so the core advances past the finished instruction
  assign lsu_busy_op       = reset & (accept || (state_q == REQ) || (state_q == WAIT_RESP));
  assign lsu_misaligned_op = reset & req_present & misaligned;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Responder for Decode's load/store request interface. Receives the enable, function code, effective address (the ALU result) and store data. Runs one transaction on the data-memory bus and returns load data plus a one-cycle valid pulse for register-file write-back.
- Sits between Decode/ALU and data memory. Provides byte-lane steering, sign/zero extension, misalignment detection, a core stall signal and a response timeout.

Parameters:
- RESP_TIMEOUT, 255, max cycles to wait in WAIT_RESP for data_rvalid_ip; 0 disables the timeout.
- CNT_WIDTH, 8, width of the timeout counter; must satisfy RESP_TIMEOUT < 2**CNT_WIDTH.

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en_lsu_ip  in  1  load/store request from Decode
- lsu_operator_ip  in  load_store_func_code  LB/LH/LW/LBU/LHU/SB/SH/SW
- addr_ip  in  32  effective byte address (ALU result)
- addr_valid_ip  in  1  addr_ip valid (ALU result valid)
- wdata_ip  in  32  store data (rs2)
- mem_data_op  out  32  extended load result
- mem_data_valid_op  out  1  one-cycle pulse: mem_data_op valid
- lsu_busy_op  out  1  stall fetch/PC while high
- lsu_misaligned_op  out  1  misaligned request flag
- lsu_timeout_op  out  1  one-cycle pulse: bus response timed out
- data_req_op  out  1  bus request
- data_gnt_ip  in  1  bus grant
- data_addr_op  out  32  word-aligned address {addr[31:2],2'b00}
- data_we_op  out  1  1 = store
- data_be_op  out  4  byte enables
- data_wdata_op  out  32  lane-steered store data
- data_rvalid_ip  in  1  response valid (loads and stores)
- data_rdata_ip  in  32  read data word

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all registered outputs 0 (mem_data_op, mem_data_valid_op, data_req_op, data_we_op, data_be_op, data_addr_op, data_wdata_op, lsu_timeout_op); timeout counter 0.
  - lsu_busy_op and lsu_misaligned_op forced 0.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- accept = state==IDLE && en_lsu_ip && addr_valid_ip && !misaligned.
- misaligned:
  - LH/LHU/SH: addr_ip[0]=1.
  - LW/SW: addr_ip[1:0]!=0.
  - LB/LBU/SB: never.
- IDLE:
  - On accept: latch op, addr_ip[1:0], lane-steered wdata and byte enables; drive data_req_op=1 and the other bus outputs from the next edge; go to REQ.
  - On a misaligned request: lsu_misaligned_op=1 combinationally in that cycle, no bus activity, stay in IDLE.
- REQ:
  - Hold data_req_op and all bus outputs stable until data_gnt_ip=1.
  - On the grant edge: drop data_req_op, clear counter, go to WAIT_RESP.
- WAIT_RESP:
  - On data_rvalid_ip: for loads, register the extended result into mem_data_op and set mem_data_valid_op=1; for stores, no valid pulse. Go to DONE.
  - Else the counter increments. If RESP_TIMEOUT!=0 and the counter reaches RESP_TIMEOUT: pulse lsu_timeout_op for one cycle, go to DONE with no valid pulse.
  - rvalid in the same cycle as the timeout: rvalid wins.
- DONE:
  - mem_data_valid_op is high for exactly this one cycle; lsu_busy_op=0 so the core advances.
  - No new request is accepted in DONE; this prevents re-issuing the still-presented instruction. Next state is IDLE.
- lsu_busy_op = accept || state==REQ || state==WAIT_RESP.
  - Latency: for a load granted in the same cycle it is requested with a 1-cycle response, the valid pulse appears 3 cycles after accept.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata_ip[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata_ip[15:0]}}.
  - SW: be=4'b1111.
- Load extraction:
  - byte/half = data_rdata_ip >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - For loads, data_be_op is set exactly as for the equivalent store width.
- Responses outside WAIT_RESP are ignored: stray data_rvalid_ip in IDLE/REQ/DONE, and data_gnt_ip outside REQ.
- Reset mid-transaction returns to IDLE immediately; a late response after reset is ignored.
- mem_data_op holds its last value between pulses.

Decomposition:
- CORE_PKG:
  - extend load_store_func_code to LB, LH, LW, LBU, LHU, SB, SH, SW;
  - add lsu_state_e {IDLE, REQ, WAIT_RESP, DONE};
  - add FUNCT3 constants for the load/store widths.
- Natural sub-module: lsu_lane_align (combinational store steering/byte-enable and load extract/extend); the FSM and counter stay in the top.

Test Plan:
- LW, addr 0x100, gnt same cycle, rvalid +1 with rdata 0xDEADBEEF -> data_addr_op=0x100, be=1111, valid pulse 1 cycle with mem_data_op=0xDEADBEEF, busy high 3 cycles.
- LB addr 0x103, rdata 0x80112233 -> mem_data_op=0xFFFFFF80; LBU -> 0x00000080; LHU addr 0x102 -> 0x00008011.
- SH addr 0x206, wdata 0x0000ABCD -> be=1100, data_wdata_op=0xABCDABCD, data_we_op=1, no mem_data_valid_op.
- LW addr 0x101 -> lsu_misaligned_op=1 same cycle, data_req_op stays 0, busy 0.
- Grant delayed 4 cycles, then RESP_TIMEOUT=3 with no rvalid -> req held stable 4 cycles; lsu_timeout_op pulses; returns to IDLE; later stray rvalid ignored.
- Reset asserted in WAIT_RESP, then rvalid -> outputs 0, no valid pulse; the following LW completes normally.
